// File: rtl/riscv_mem_responder_pkg.sv
// riscv_mem_pkg: shared definitions for the RV32I memory responder.
//   - funct3 encodings for loads/stores
//   - per-port FSM state enum
//   - access_bad():   alignment / size legality of a latched request
//   - load_extract(): lane select + sign/zero extension of a loaded word
//   - store_merge():  byte-lane merge of store data into an existing word
// The helper functions operate on 32-bit little-endian words.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } port_state_e;

  // 1 when the size/alignment combination is illegal (range is checked by the top).
  function automatic logic access_bad(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] lo2);
    logic bad;
    bad = 1'b0;
    if (we) begin
      case (funct3)
        F3_SB:   bad = 1'b0;
        F3_SH:   bad = lo2[0];
        F3_SW:   bad = (lo2 != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: bad = 1'b0;
        F3_LH, F3_LHU: bad = lo2[0];
        F3_LW:         bad = (lo2 != 2'b00);
        default:       bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lo2,
                                               input logic [2:0] funct3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo2, 3'b000} +: 8];
    h = word[{lo2[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LW:   r = word;
      F3_LBU:  r = {24'b0, b};
      F3_LHU:  r = {16'b0, h};
      default: r = 32'b0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] lo2, input logic [2:0] funct3);
    logic [31:0] r;
    r = word;
    case (funct3)
      F3_SB:   r[{lo2, 3'b000} +: 8] = wdata[7:0];
      F3_SH:   r[{lo2[1], 4'b0000} +: 16] = wdata[15:0];
      F3_SW:   r = wdata;
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_mem_responder_if.sv
// riscv_mem_responder_if: bus bundle between the core (master) and the
// memory responder (slave).
//   fetch port: if_req/if_addr -> if_ack/if_rdata/if_err
//   data  port: d_req/d_we/d_addr/d_wdata/d_funct3 -> d_ack/d_rdata/d_err
interface riscv_mem_responder_if #(parameter int XLEN = 32);
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_ack;
  logic [XLEN-1:0] if_rdata;
  logic            if_err;

  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [2:0]      d_funct3;
  logic            d_ack;
  logic [XLEN-1:0] d_rdata;
  logic            d_err;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err
  );
endinterface

// File: rtl/riscv_mem_responder_port_fsm.sv
// riscv_mem_port_fsm: req/ack handshake for one memory port.
//   clk, rst       : clock, asynchronous active-low reset
//   req_i + fields : request, sampled only at acceptance in IDLE
//   ack_o          : registered one-cycle response strobe (RESP state)
//   commit_o       : high in the cycle whose closing edge performs the access
//   *_o fields     : latched request fields
module riscv_mem_port_fsm
  import riscv_mem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [2:0]      funct3_i,
  output logic            ack_o,
  output logic            commit_o,
  output logic            we_o,
  output logic [XLEN-1:0] addr_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [2:0]      funct3_o
);
  port_state_e     state_q;
  logic [3:0]      cnt_q;
  logic            ack_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      funct3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      ack_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            we_q     <= we_i;
            addr_q   <= addr_i;
            wdata_q  <= wdata_i;
            funct3_q <= funct3_i;
            cnt_q    <= 4'(WAIT_CYCLES);
            state_q  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_RESP;
            ack_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        // Always pass through IDLE so a held req is re-accepted one edge after ack falls.
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign commit_o = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign ack_o    = ack_q;
  assign we_o     = we_q;
  assign addr_o   = addr_q;
  assign wdata_o  = wdata_q;
  assign funct3_o = funct3_q;
endmodule

// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder: shared word array serving a fetch port (index 0) and a
// load/store data port (index 1), each with its own handshake FSM.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : riscv_mem_responder_if.slave (fetch and data request/response)
// The array has one write port (data stores) and a read per port; all reads in
// a given edge see the array contents from before that edge's write.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst,
  riscv_mem_responder_if.slave bus
);
  localparam int NP = 2;
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [XLEN-1:0] DEPTH_L = XLEN'(DEPTH_WORDS);

  logic            req_w    [NP];
  logic            we_w     [NP];
  logic [XLEN-1:0] addr_w   [NP];
  logic [XLEN-1:0] wdata_w  [NP];
  logic [2:0]      f3_w     [NP];
  logic            ack_w    [NP];
  logic            commit_w [NP];
  logic            we_q     [NP];
  logic [XLEN-1:0] addr_q   [NP];
  logic [XLEN-1:0] wdata_q  [NP];
  logic [2:0]      f3_q     [NP];
  logic            err_w    [NP];
  logic [AW-1:0]   idx_w    [NP];
  logic [XLEN-1:0] rdata_w  [NP];
  logic            rerr_w   [NP];

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  // Fetch behaves as a word load that can never write.
  assign req_w[0]   = bus.if_req;
  assign we_w[0]    = 1'b0;
  assign addr_w[0]  = bus.if_addr;
  assign wdata_w[0] = '0;
  assign f3_w[0]    = F3_LW;

  assign req_w[1]   = bus.d_req;
  assign we_w[1]    = bus.d_we;
  assign addr_w[1]  = bus.d_addr;
  assign wdata_w[1] = bus.d_wdata;
  assign f3_w[1]    = bus.d_funct3;

  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_port
      logic [XLEN-1:0] rdata_q;
      logic            err_q;

      riscv_mem_port_fsm #(
        .XLEN        (XLEN),
        .WAIT_CYCLES (WAIT_CYCLES)
      ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_w[gi]),
        .we_i     (we_w[gi]),
        .addr_i   (addr_w[gi]),
        .wdata_i  (wdata_w[gi]),
        .funct3_i (f3_w[gi]),
        .ack_o    (ack_w[gi]),
        .commit_o (commit_w[gi]),
        .we_o     (we_q[gi]),
        .addr_o   (addr_q[gi]),
        .wdata_o  (wdata_q[gi]),
        .funct3_o (f3_q[gi])
      );

      assign idx_w[gi] = addr_q[gi][AW+1:2];
      // Full upper address is compared so out-of-range accesses never alias.
      assign err_w[gi] = ({2'b00, addr_q[gi][XLEN-1:2]} >= DEPTH_L) ||
                         access_bad(we_q[gi], f3_q[gi], addr_q[gi][1:0]);

      // Response data only changes on the commit edge and holds otherwise.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end else if (commit_w[gi]) begin
          err_q   <= err_w[gi];
          rdata_q <= (err_w[gi] || we_q[gi]) ? '0 :
                     load_extract(mem_q[idx_w[gi]], addr_q[gi][1:0], f3_q[gi]);
        end
      end

      assign rdata_w[gi] = rdata_q;
      assign rerr_w[gi]  = err_q;
    end
  endgenerate

  // Single write port: pick whichever port commits a legal store this edge.
  logic wr_en;
  logic wr_port;

  always_comb begin
    wr_en   = 1'b0;
    wr_port = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (commit_w[i] && we_q[i] && !err_w[i]) begin
        wr_en   = 1'b1;
        wr_port = 1'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx_w[wr_port]] <= store_merge(mem_q[idx_w[wr_port]], wdata_q[wr_port],
                                           addr_q[wr_port][1:0], f3_q[wr_port]);
    end
  end

  assign bus.if_ack   = ack_w[0];
  assign bus.if_rdata = rdata_w[0];
  assign bus.if_err   = rerr_w[0];
  assign bus.d_ack    = ack_w[1];
  assign bus.d_rdata  = rdata_w[1];
  assign bus.d_err    = rerr_w[1];
endmodule

// File: tb/tb_riscv_mem_responder.sv
// Scoreboard bench for riscv_mem_responder: drivers push expected responses,
// a negedge monitor pops and compares on every ack.
module tb_riscv_mem_responder;
  import riscv_mem_pkg::*;

  localparam int WAIT  = 1;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t fq[$];
  exp_t dq[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  int   d_ack_cnt = 0;
  logic prev_f_ack = 1'b0;
  logic prev_d_ack = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  riscv_mem_responder_if #(.XLEN(32)) bus();

  riscv_mem_responder #(
    .XLEN        (32),
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAIT)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: compare every ack against the head of its scoreboard queue.
  always @(negedge clk) begin
    if (bus.d_ack === 1'b1) begin
      d_ack_cnt++;
      chk("d_ack_width", {31'b0, prev_d_ack}, 32'd0);
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL d_unexpected_ack: ack seen with nothing outstanding");
      end else begin
        me = dq.pop_front();
        checks++;
        if (bus.d_rdata !== me.rdata || bus.d_err !== me.err) begin
          errors++;
          $display("FAIL %s: rdata=%h err=%b, want rdata=%h err=%b",
                   me.name, bus.d_rdata, bus.d_err, me.rdata, me.err);
        end else begin
          $display("ok   %s: rdata=%h err=%b", me.name, bus.d_rdata, bus.d_err);
        end
      end
    end
    if (bus.if_ack === 1'b1) begin
      chk("if_ack_width", {31'b0, prev_f_ack}, 32'd0);
      if (fq.size() == 0) begin
        checks++; errors++;
        $display("FAIL if_unexpected_ack: ack seen with nothing outstanding");
      end else begin
        me = fq.pop_front();
        checks++;
        if (bus.if_rdata !== me.rdata || bus.if_err !== me.err) begin
          errors++;
          $display("FAIL %s: rdata=%h err=%b, want rdata=%h err=%b",
                   me.name, bus.if_rdata, bus.if_err, me.rdata, me.err);
        end else begin
          $display("ok   %s: rdata=%h err=%b", me.name, bus.if_rdata, bus.if_err);
        end
      end
    end
    prev_d_ack = bus.d_ack;
    prev_f_ack = bus.if_ack;
  end

  task automatic d_access(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    exp_t e;
    e.rdata = exp_rdata; e.err = exp_err; e.name = name;
    dq.push_back(e);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_funct3 = f3;
    bus.d_addr = addr; bus.d_wdata = wdata;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.d_ack !== 1'b1 && n < 40);
    chk({name, "_latency"}, 32'(n), 32'(WAIT + 2));
    bus.d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic f_access(input string name, input logic [31:0] addr,
                          input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    exp_t e;
    e.rdata = exp_rdata; e.err = exp_err; e.name = name;
    fq.push_back(e);
    bus.if_req = 1'b1; bus.if_addr = addr;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.if_ack !== 1'b1 && n < 40);
    chk({name, "_latency"}, 32'(n), 32'(WAIT + 2));
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_if_ack"},   {31'b0, bus.if_ack}, 32'd0);
    chk({tag, "_if_rdata"}, bus.if_rdata,        32'd0);
    chk({tag, "_if_err"},   {31'b0, bus.if_err}, 32'd0);
    chk({tag, "_d_ack"},    {31'b0, bus.d_ack},  32'd0);
    chk({tag, "_d_rdata"},  bus.d_rdata,         32'd0);
    chk({tag, "_d_err"},    {31'b0, bus.d_err},  32'd0);
  endtask

  logic [31:0] hold_addr [3];
  logic [31:0] hold_data [3];

  initial begin
    int acks;
    int cyc;
    int base;
    exp_t e;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_funct3 = 3'b0;
    repeat (3) @(negedge clk);
    outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Basic word store/load and byte/halfword lanes.
    d_access("sw_10",  1'b1, F3_SW,  32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
    d_access("lw_10",  1'b0, F3_LW,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    d_access("sw_00",  1'b1, F3_SW,  32'h00,  32'h0,        32'h0,        1'b0);
    d_access("sw_20",  1'b1, F3_SW,  32'h20,  32'h0,        32'h0,        1'b0);
    d_access("sb_21",  1'b1, F3_SB,  32'h21,  32'h80,       32'h0,        1'b0);
    d_access("lb_21",  1'b0, F3_LB,  32'h21,  32'h0,        32'hFFFFFF80, 1'b0);
    d_access("lbu_21", 1'b0, F3_LBU, 32'h21,  32'h0,        32'h00000080, 1'b0);
    d_access("lw_20a", 1'b0, F3_LW,  32'h20,  32'h0,        32'h00008000, 1'b0);
    d_access("sh_22",  1'b1, F3_SH,  32'h22,  32'hBEEF,     32'h0,        1'b0);
    d_access("lh_22",  1'b0, F3_LH,  32'h22,  32'h0,        32'hFFFFBEEF, 1'b0);
    d_access("lhu_22", 1'b0, F3_LHU, 32'h22,  32'h0,        32'h0000BEEF, 1'b0);
    d_access("lb_23",  1'b0, F3_LB,  32'h23,  32'h0,        32'hFFFFFFBE, 1'b0);
    d_access("lw_20b", 1'b0, F3_LW,  32'h20,  32'h0,        32'hBEEF8000, 1'b0);
    d_access("sw_ffc", 1'b1, F3_SW,  32'hFFC, 32'hCAFEF00D, 32'h0,        1'b0);
    d_access("lw_ffc", 1'b0, F3_LW,  32'hFFC, 32'h0,        32'hCAFEF00D, 1'b0);

    // Error cases: err=1, rdata=0, memory untouched.
    d_access("lh_13_err",   1'b0, F3_LH,  32'h13,       32'h0,        32'h0, 1'b1);
    d_access("sw_1002_err", 1'b1, F3_SW,  32'h1002,     32'h11111111, 32'h0, 1'b1);
    d_access("sw_12_err",   1'b1, F3_SW,  32'h12,       32'h22222222, 32'h0, 1'b1);
    d_access("sh_11_err",   1'b1, F3_SH,  32'h11,       32'h3333,     32'h0, 1'b1);
    d_access("sb_oor_err",  1'b1, F3_SB,  32'h1000,     32'h44,       32'h0, 1'b1);
    d_access("lw_oor_err",  1'b0, F3_LW,  32'(4*DEPTH), 32'h0,        32'h0, 1'b1);
    d_access("ld_011_err",  1'b0, 3'b011, 32'h10,       32'h0,        32'h0, 1'b1);
    d_access("st_100_err",  1'b1, 3'b100, 32'h10,       32'h55555555, 32'h0, 1'b1);
    f_access("f_12_err",  32'h12,   32'h0, 1'b1);
    f_access("f_oor_err", 32'h1000, 32'h0, 1'b1);
    d_access("lw_10_kept", 1'b0, F3_LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    d_access("lw_00_kept", 1'b0, F3_LW, 32'h00, 32'h0, 32'h0,        1'b0);

    // Fetch and store to the same word on the same edge: fetch sees the old word.
    fork
      f_access("f_10_old", 32'h10, 32'hDEADBEEF, 1'b0);
      d_access("sw_10_new", 1'b1, F3_SW, 32'h10, 32'h12345678, 32'h0, 1'b0);
    join
    f_access("f_10_new", 32'h10, 32'h12345678, 1'b0);

    // req held high across three loads.
    hold_addr[0] = 32'h10;  hold_data[0] = 32'h12345678;
    hold_addr[1] = 32'h20;  hold_data[1] = 32'hBEEF8000;
    hold_addr[2] = 32'hFFC; hold_data[2] = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      e.rdata = hold_data[i]; e.err = 1'b0; e.name = $sformatf("hold_lw_%0d", i);
      dq.push_back(e);
    end
    base = d_ack_cnt;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_funct3 = F3_LW; bus.d_addr = hold_addr[0];
    acks = 0; cyc = 0;
    while (acks < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.d_ack === 1'b1) begin
        acks++;
        if (acks < 3) bus.d_addr = hold_addr[acks];
      end
    end
    bus.d_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_ack_count", 32'(d_ack_cnt - base), 32'd3);

    // Reset during BUSY of a store: no ack, outputs cleared, store dropped.
    d_access("sw_40", 1'b1, F3_SW, 32'h40, 32'h01020304, 32'h0, 1'b0);
    f_access("f_20",  32'h20, 32'hBEEF8000, 1'b0);
    d_access("lw_40", 1'b0, F3_LW, 32'h40, 32'h0, 32'h01020304, 1'b0);
    base = d_ack_cnt;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_funct3 = F3_SW;
    bus.d_addr = 32'h40; bus.d_wdata = 32'hAAAAAAAA;
    @(negedge clk);
    rst = 1'b0;
    #1;
    outputs_zero("abort");
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);
    outputs_zero("abort_hold");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_ack", 32'(d_ack_cnt - base), 32'd0);
    d_access("lw_40_after", 1'b0, F3_LW, 32'h40, 32'h0, 32'h01020304, 1'b0);

    chk("fq_drained", 32'(fq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
